// File: rtl/ula_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and the iteration count.
package ula_pkg;

   localparam int N_ITER = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_md_t;

   typedef enum logic [1:0] {
      OCIOSO = 2'b00,
      CALC   = 2'b01,
      AJUSTE = 2'b10
   } estado_md_t;

   function automatic logic op_com_sinal(input op_md_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic op_eh_div(input op_md_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/ula_multdiv_if.sv
// Start/busy/done handshake and operand/result bus between the control unit
// and the multiply/divide unit.
interface ula_multdiv_if #(
   parameter int N_BITS = 32
);
   logic              inicio;
   logic [1:0]        op;
   logic [N_BITS-1:0] SrcA;
   logic [N_BITS-1:0] SrcB;
   logic              ocupado;
   logic              pronto;
   logic [N_BITS-1:0] HI;
   logic [N_BITS-1:0] LO;
   logic              div_zero;

   modport master (
      output inicio, op, SrcA, SrcB,
      input  ocupado, pronto, HI, LO, div_zero
   );

   modport slave (
      input  inicio, op, SrcA, SrcB,
      output ocupado, pronto, HI, LO, div_zero
   );
endinterface

// File: rtl/ula_md_passo.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational.
module ula_md_passo #(
   parameter int N_BITS = 32
) (
   input  logic [N_BITS:0]   acc_hi,
   input  logic [N_BITS-1:0] acc_lo,
   input  logic [N_BITS-1:0] opnd,
   input  logic              is_div,
   output logic [N_BITS:0]   acc_hi_nx,
   output logic [N_BITS-1:0] acc_lo_nx
);

   logic [N_BITS:0]   soma;
   logic [N_BITS:0]   r_desl;
   logic [N_BITS+1:0] dif;

   always_comb begin
      soma   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
      r_desl = {acc_hi[N_BITS-1:0], acc_lo[N_BITS-1]};
      // One extra bit so the sign of the trial subtraction is explicit
      dif    = {1'b0, r_desl} - {2'b00, opnd};

      if (is_div) begin
         if (!dif[N_BITS+1]) begin
            acc_hi_nx = dif[N_BITS:0];
            acc_lo_nx = {acc_lo[N_BITS-2:0], 1'b1};
         end else begin
            acc_hi_nx = r_desl;
            acc_lo_nx = {acc_lo[N_BITS-2:0], 1'b0};
         end
      end else begin
         acc_hi_nx = {1'b0, soma[N_BITS:1]};
         acc_lo_nx = {soma[0], acc_lo[N_BITS-1:1]};
      end
   end

endmodule

// File: rtl/ula_multdiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing a 2*N_BITS result into HI/LO,
// one radix-2 step per clock with a fixed latency for every operation.
module ula_multdiv
   import ula_pkg::*;
#(
   parameter int N_BITS = N_ITER
) (
   input logic          clk,
   input logic          reset_n,
   ula_multdiv_if.slave bus
);

   localparam int CW = $clog2(N_BITS);

   estado_md_t          estado_q, estado_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_BITS-1:0]   hi_q, hi_d;
   logic [N_BITS-1:0]   lo_q, lo_d;
   logic                div_zero_q, div_zero_d;
   logic                pronto_q, pronto_d;

   op_md_t              op_q, op_d;
   logic [N_BITS-1:0]   opnd_q, opnd_d;
   logic [N_BITS-1:0]   raw_a_q, raw_a_d;
   logic [N_BITS:0]     acc_hi_q, acc_hi_d;
   logic [N_BITS-1:0]   acc_lo_q, acc_lo_d;
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic                dz_q, dz_d;

   op_md_t              op_in;
   logic                sinal_in;
   logic [N_BITS-1:0]   mag_a, mag_b;
   logic                is_div;
   logic [N_BITS:0]     acc_hi_nx;
   logic [N_BITS-1:0]   acc_lo_nx;
   logic [2*N_BITS-1:0] prod_mag, prod_fix;
   logic [N_BITS-1:0]   quoc_fix, resto_fix;

   function automatic logic [N_BITS-1:0] magnitude(input logic [N_BITS-1:0] v,
                                                   input logic              com_sinal);
      return (com_sinal && v[N_BITS-1]) ? -v : v;
   endfunction

   assign op_in    = op_md_t'(bus.op);
   assign sinal_in = op_com_sinal(op_in);
   assign mag_a    = magnitude(bus.SrcA, sinal_in);
   assign mag_b    = magnitude(bus.SrcB, sinal_in);
   assign is_div   = op_eh_div(op_q);

   ula_md_passo #(
      .N_BITS (N_BITS)
   ) u_passo (
      .acc_hi    (acc_hi_q),
      .acc_lo    (acc_lo_q),
      .opnd      (opnd_q),
      .is_div    (is_div),
      .acc_hi_nx (acc_hi_nx),
      .acc_lo_nx (acc_lo_nx)
   );

   // Sign fix-up; magnitudes wrap naturally, so -2^(N-1)/-1 yields 0x80..0
   assign prod_mag  = {acc_hi_q[N_BITS-1:0], acc_lo_q};
   assign prod_fix  = neg_res_q ? -prod_mag : prod_mag;
   assign quoc_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
   assign resto_fix = neg_rem_q ? -acc_hi_q[N_BITS-1:0] : acc_hi_q[N_BITS-1:0];

   always_comb begin
      estado_d   = estado_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
      pronto_d   = 1'b0;
      op_d       = op_q;
      opnd_d     = opnd_q;
      raw_a_d    = raw_a_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      neg_res_d  = neg_res_q;
      neg_rem_d  = neg_rem_q;
      dz_d       = dz_q;

      case (estado_q)
         OCIOSO: begin
            if (bus.inicio) begin
               estado_d  = CALC;
               cnt_d     = CW'(N_BITS - 1);
               op_d      = op_in;
               raw_a_d   = bus.SrcA;
               acc_hi_d  = '0;
               neg_res_d = sinal_in && (bus.SrcA[N_BITS-1] ^ bus.SrcB[N_BITS-1]);
               neg_rem_d = sinal_in && bus.SrcA[N_BITS-1];
               if (op_eh_div(op_in)) begin
                  acc_lo_d = mag_a;
                  opnd_d   = mag_b;
                  dz_d     = (bus.SrcB == '0);
               end else begin
                  acc_lo_d = mag_b;
                  opnd_d   = mag_a;
                  dz_d     = 1'b0;
               end
            end
         end

         CALC: begin
            acc_hi_d = acc_hi_nx;
            acc_lo_d = acc_lo_nx;
            if (cnt_q == '0) begin
               estado_d = AJUSTE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         AJUSTE: begin
            estado_d   = OCIOSO;
            pronto_d   = 1'b1;
            div_zero_d = 1'b0;
            if (!is_div) begin
               hi_d = prod_fix[2*N_BITS-1:N_BITS];
               lo_d = prod_fix[N_BITS-1:0];
            end else if (dz_q) begin
               div_zero_d = 1'b1;
               hi_d       = raw_a_q;
               lo_d       = '1;
            end else begin
               hi_d = resto_fix;
               lo_d = quoc_fix;
            end
         end

         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         estado_q   <= OCIOSO;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
         pronto_q   <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
         pronto_q   <= pronto_d;
      end
   end

   // Operand latches and accumulator are only meaningful while busy
   always_ff @(posedge clk) begin
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      raw_a_q   <= raw_a_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
   end

   assign bus.ocupado  = (estado_q != OCIOSO);
   assign bus.pronto   = pronto_q;
   assign bus.HI       = hi_q;
   assign bus.LO       = lo_q;
   assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_ula_multdiv.sv
// Bench for ula_multdiv: directed and random operations, checked every cycle
// against a behavioural reference built on native 64-bit arithmetic.
module tb_ula_multdiv;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ula_multdiv_if #(.N_BITS(32)) bus ();

   ula_multdiv #(.N_BITS(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [64:0] exp;
   } lit_t;

   lit_t lit_tab [11];

   int nerr = 0;
   int nchk = 0;
   logic chk_en = 1'b0;
   logic pinned = 1'b0;

   // Reference result {div_zero, HI, LO} computed from the arithmetic meaning
   function automatic logic [64:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint             sp;
      logic [63:0]        up;
      logic signed [31:0] sq, sr;
      case (op)
         2'b00: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return {1'b0, 64'(sp)};
         end
         2'b01: begin
            up = {32'b0, a} * {32'b0, b};
            return {1'b0, up};
         end
         2'b10: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            return {1'b0, sr, sq};
         end
         default: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   // Timing model: 33 edges from accepted start to result/pronto
   int          cnt_m;
   logic [64:0] pend_m;
   logic [31:0] m_hi, m_lo;
   logic        m_dz, m_pronto;

   always @(posedge clk) begin
      if (!reset_n) begin
         cnt_m    <= 0;
         m_hi     <= 32'd0;
         m_lo     <= 32'd0;
         m_dz     <= 1'b0;
         m_pronto <= 1'b0;
      end else if (cnt_m == 0) begin
         m_pronto <= 1'b0;
         if (bus.inicio) begin
            cnt_m  <= 33;
            pend_m <= ref_md(bus.op, bus.SrcA, bus.SrcB);
         end
      end else begin
         cnt_m <= cnt_m - 1;
         if (cnt_m == 1) begin
            m_dz     <= pend_m[64];
            m_hi     <= pend_m[63:32];
            m_lo     <= pend_m[31:0];
            m_pronto <= 1'b1;
         end else begin
            m_pronto <= 1'b0;
         end
      end
   end

   // Single compare process: pins the model once, then checks every cycle
   always @(negedge clk) begin
      logic [66:0] got, exp;
      logic [64:0] r;
      if (chk_en) begin
         if (!pinned) begin
            pinned <= 1'b1;
            for (int i = 0; i < 11; i++) begin
               r = ref_md(lit_tab[i].op, lit_tab[i].a, lit_tab[i].b);
               nchk++;
               if (r !== lit_tab[i].exp) begin
                  nerr++;
                  $display("FAIL model_lit[%0d] got=%h required=%h", i, r, lit_tab[i].exp);
               end
            end
         end
         got = {bus.ocupado, bus.pronto, bus.div_zero, bus.HI, bus.LO};
         exp = {(cnt_m != 0), m_pronto, m_dz, m_hi, m_lo};
         nchk++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL cycle t=%0t {ocupado,pronto,div_zero,HI,LO} got=%b,%b,%b,%h,%h required=%b,%b,%b,%h,%h",
                     $time, got[66], got[65], got[64], got[63:32], got[31:0],
                     exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
         end
      end
   end

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int gap, input logic noise);
      @(negedge clk);
      bus.inicio = 1'b1;
      bus.op     = o;
      bus.SrcA   = a;
      bus.SrcB   = b;
      @(negedge clk);
      bus.inicio = 1'b0;
      bus.SrcA   = $urandom;
      bus.SrcB   = $urandom;
      for (int j = 0; j < gap; j++) begin
         @(negedge clk);
         bus.inicio = noise && (j < 30) && ($urandom_range(0, 3) == 0);
         bus.op     = 2'($urandom_range(0, 3));
         bus.SrcA   = $urandom;
         bus.SrcB   = $urandom;
      end
      bus.inicio = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      lit_tab[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001}};
      lit_tab[1]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB}};
      lit_tab[2]  = '{2'b00, 32'h80000000, 32'h80000000, {1'b0, 32'h40000000, 32'h00000000}};
      lit_tab[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}};
      lit_tab[4]  = '{2'b11, 32'h80000000, 32'd3,        {1'b0, 32'h00000002, 32'h2AAAAAAA}};
      lit_tab[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h00000000, 32'h80000000}};
      lit_tab[6]  = '{2'b10, 32'd5,        32'd0,        {1'b1, 32'h00000005, 32'hFFFFFFFF}};
      lit_tab[7]  = '{2'b11, 32'd10,       32'd3,        {1'b0, 32'h00000001, 32'h00000003}};
      lit_tab[8]  = '{2'b01, 32'd6,        32'd7,        {1'b0, 32'h00000000, 32'd42}};
      lit_tab[9]  = '{2'b01, 32'd2,        32'd3,        {1'b0, 32'h00000000, 32'd6}};
      lit_tab[10] = '{2'b11, 32'd9,        32'd4,        {1'b0, 32'h00000001, 32'h00000002}};

      bus.inicio = 1'b0;
      bus.op     = 2'b00;
      bus.SrcA   = 32'd0;
      bus.SrcB   = 32'd0;
      reset_n    = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Directed cases, including back-to-back acceptance on the pronto cycle
      for (int i = 0; i < 8; i++)
         run_op(lit_tab[i].op, lit_tab[i].a, lit_tab[i].b, (i % 2 == 0) ? 32 : 34, 1'b1);
      repeat (3) @(negedge clk);

      // Start, ignored mid-op start at E10, reset at E20, then restart
      @(negedge clk);
      bus.inicio = 1'b1; bus.op = 2'b01; bus.SrcA = 32'd6; bus.SrcB = 32'd7;
      @(negedge clk);
      bus.inicio = 1'b0;
      repeat (8) @(negedge clk);
      bus.inicio = 1'b1; bus.op = 2'b11; bus.SrcA = 32'd100; bus.SrcB = 32'd9;
      @(negedge clk);
      bus.inicio = 1'b0;
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      run_op(2'b01, 32'd6, 32'd7, 36, 1'b0);

      // inicio held high: MULTU 2x3, then DIVU 9/4 taken on the pronto cycle
      @(negedge clk);
      bus.inicio = 1'b1; bus.op = 2'b01; bus.SrcA = 32'd2; bus.SrcB = 32'd3;
      @(negedge clk);
      bus.op = 2'b11; bus.SrcA = 32'd9; bus.SrcB = 32'd4;
      repeat (34) @(negedge clk);
      bus.inicio = 1'b0;
      repeat (40) @(negedge clk);

      // Randomised operations with random gaps and ignored mid-op starts
      for (int k = 0; k < 40; k++)
         run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                $urandom_range(32, 36), 1'b1);

      // Random reset during an operation
      run_op(2'b10, $urandom, $urandom, 5, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);

      chk_en = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
